// File: rtl/mathrix_pkg.sv
// Shared types and widths for the round sequencer: FSM state encoding and counter widths.
package mathrix_pkg;

  localparam int TIMER_W    = 7;
  localparam int SCORE_W    = 3;
  localparam int ARM_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PLAY,
    SCORE,
    ABORT,
    GAME_OVER
  } state_e;

endpackage

// File: rtl/round_timer_ctrl_if.sv
// Handshake between the round sequencer (master) and the equation1 stage (slave).
interface round_timer_ctrl_if;

  logic                             startEq1;
  logic                             EqAbort;
  logic [mathrix_pkg::TIMER_W-1:0]  OngoingTimer;
  logic                             correct;

  modport master (
    output startEq1,
    output EqAbort,
    output OngoingTimer,
    input  correct
  );

  modport slave (
    input  startEq1,
    input  EqAbort,
    input  OngoingTimer,
    output correct
  );

endinterface

// File: rtl/round_timer_ctrl_sec_prescaler.sv
// Divides Clock down to a one-cycle tick per second; counts only while en, clr restarts the second.
module sec_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/round_timer_ctrl.sv
// Game-round sequencer: launches equation1, runs the per-round countdown, tracks score and rounds.
// Optional build macro MATHRIX_PAUSE_EN adds a Pause input that freezes the countdown in PLAY.
module round_timer_ctrl
  import mathrix_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int ROUND_SECS = 60,
  parameter int MAX_ROUNDS = 5
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
`ifdef MATHRIX_PAUSE_EN
  input  logic                  Pause,
`endif
  round_timer_ctrl_if.master    eq_if,
  output logic [SCORE_W-1:0]    Score,
  output logic [SCORE_W-1:0]    RoundNum,
  output logic                  Timeout,
  output logic                  GameOver
);

  localparam int ARM_CNT_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_CNT_W-1:0] ARM_LAST   = ARM_CNT_W'(ARM_CYCLES - 1);
  localparam logic [TIMER_W-1:0]   ROUND_T    = TIMER_W'(ROUND_SECS);
  localparam logic [SCORE_W-1:0]   LAST_ROUND = SCORE_W'(MAX_ROUNDS);

  state_e                 state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [SCORE_W-1:0]     round_q, round_d;
  logic [ARM_CNT_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic                   tick;
  logic                   run;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef MATHRIX_PAUSE_EN
  assign run = !Pause;
`else
  assign run = 1'b1;
`endif

  sec_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_presc (
    .Clock (Clock),
    .Reset (Reset),
    .clr   (state_q == ARM),
    .en    ((state_q == PLAY) && run),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    score_d   = score_q;
    round_d   = round_q;
    arm_cnt_d = arm_cnt_q;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (Start) begin
          state_d   = ARM;
          score_d   = '0;
          round_d   = SCORE_W'(1);
          arm_cnt_d = '0;
        end
      end
      ARM: begin
        // Timer is loaded after the first strobe cycle so it is stable when equation1 latches it.
        if (arm_cnt_q == '0) timer_d = ROUND_T;
        if (arm_cnt_q == ARM_LAST) begin
          state_d   = PLAY;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      PLAY: begin
        if (tick && (timer_q != '0)) timer_d = timer_q - 1'b1;
        if (eq_if.correct) begin
          state_d = SCORE;
        end else if (tick && (timer_q == '0)) begin
          state_d = ABORT;
        end
      end
      SCORE, ABORT: begin
        if (state_q == SCORE) score_d = sat_inc(score_q);
        if (round_q == LAST_ROUND) begin
          state_d = GAME_OVER;
        end else begin
          round_d = round_q + 1'b1;
          state_d = ARM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      score_q   <= '0;
      round_q   <= '0;
      arm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      score_q   <= score_d;
      round_q   <= round_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  assign eq_if.startEq1     = (state_q == ARM);
  assign eq_if.EqAbort      = (state_q == ABORT);
  assign eq_if.OngoingTimer = timer_q;
  assign Timeout            = (state_q == ABORT);
  assign GameOver           = (state_q == GAME_OVER);
  assign Score              = score_q;
  assign RoundNum           = round_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl at CLK_HZ=4, ROUND_SECS=3, MAX_ROUNDS=2.
module tb_round_timer_ctrl;

  logic       Clock;
  logic       Reset;
  logic       Start;
`ifdef MATHRIX_PAUSE_EN
  logic       Pause;
`endif
  logic [2:0] Score;
  logic [2:0] RoundNum;
  logic       Timeout;
  logic       GameOver;

  int n_checks = 0;
  int n_errors = 0;

  round_timer_ctrl_if eq_if ();

  round_timer_ctrl #(
    .CLK_HZ     (4),
    .ROUND_SECS (3),
    .MAX_ROUNDS (2)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
`ifdef MATHRIX_PAUSE_EN
    .Pause    (Pause),
`endif
    .eq_if    (eq_if),
    .Score    (Score),
    .RoundNum (RoundNum),
    .Timeout  (Timeout),
    .GameOver (GameOver)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_startEq1"}, 32'(eq_if.startEq1), 0);
    chk({pfx, "_EqAbort"},  32'(eq_if.EqAbort), 0);
    chk({pfx, "_timer"},    32'(eq_if.OngoingTimer), 0);
    chk({pfx, "_score"},    32'(Score), 0);
    chk({pfx, "_round"},    32'(RoundNum), 0);
    chk({pfx, "_timeout"},  32'(Timeout), 0);
    chk({pfx, "_gameover"}, 32'(GameOver), 0);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    eq_if.correct = 1'b0;
`ifdef MATHRIX_PAUSE_EN
    Pause = 1'b0;
`endif
    repeat (3) cyc();
    chk_all_zero("reset");
    Reset = 1'b0;
    cyc();

    // correct while idle is ignored
    eq_if.correct = 1'b1;
    cyc();
    eq_if.correct = 1'b0;
    cyc();
    chk("idle_correct_round", 32'(RoundNum), 0);
    chk("idle_correct_strobe", 32'(eq_if.startEq1), 0);

    // Game 1, round 1: launch strobe
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk("g1r1_strobe0", 32'(eq_if.startEq1), 1);
    chk("g1r1_round", 32'(RoundNum), 1);
    chk("g1r1_score", 32'(Score), 0);
    cyc();
    chk("g1r1_strobe1", 32'(eq_if.startEq1), 1);
    chk("g1r1_timer_load", 32'(eq_if.OngoingTimer), 3);
    cyc();
    chk("g1r1_strobe_end", 32'(eq_if.startEq1), 0);

    // countdown 3,2,1,0 at 4-cycle spacing
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("g1r1_timer_c%0d", i), 32'(eq_if.OngoingTimer), 32'(3 - i / 4));
      chk($sformatf("g1r1_no_to_c%0d", i), 32'(Timeout), 0);
      cyc();
    end
    chk("g1r1_timeout", 32'(Timeout), 1);
    chk("g1r1_eqabort", 32'(eq_if.EqAbort), 1);
    chk("g1r1_timer_floor", 32'(eq_if.OngoingTimer), 0);

    // round 2 arm; a correct pulse during ARM must be ignored
    eq_if.correct = 1'b1;
    cyc();
    eq_if.correct = 1'b0;
    chk("g1r2_timeout_1cyc", 32'(Timeout), 0);
    chk("g1r2_eqabort_1cyc", 32'(eq_if.EqAbort), 0);
    chk("g1r2_round", 32'(RoundNum), 2);
    chk("g1r2_strobe0", 32'(eq_if.startEq1), 1);
    cyc();
    chk("g1r2_strobe1", 32'(eq_if.startEq1), 1);
    chk("g1r2_timer_load", 32'(eq_if.OngoingTimer), 3);
    cyc();
    chk("g1r2_strobe_end", 32'(eq_if.startEq1), 0);
    chk("g1r2_arm_correct_ignored", 32'(Score), 0);

    // correct coincides with the expiry tick
    repeat (15) cyc();
    chk("g1r2_timer_zero", 32'(eq_if.OngoingTimer), 0);
    eq_if.correct = 1'b1;
    cyc();
    eq_if.correct = 1'b0;
    chk("g1r2_tie_timeout", 32'(Timeout), 0);
    chk("g1r2_tie_eqabort", 32'(eq_if.EqAbort), 0);
    cyc();
    chk("g1_over", 32'(GameOver), 1);
    chk("g1_score", 32'(Score), 1);
    chk("g1_round_held", 32'(RoundNum), 2);
    chk("g1_over_timeout", 32'(Timeout), 0);
    repeat (3) cyc();
    chk("g1_over_hold", 32'(GameOver), 1);
    chk("g1_score_hold", 32'(Score), 1);

    // Game 2: restart from GAME_OVER
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk("g2r1_score_clr", 32'(Score), 0);
    chk("g2r1_round", 32'(RoundNum), 1);
    chk("g2r1_gameover_clr", 32'(GameOver), 0);
    chk("g2r1_strobe0", 32'(eq_if.startEq1), 1);
    cyc();
    chk("g2r1_strobe1", 32'(eq_if.startEq1), 1);
    cyc();
    chk("g2r1_strobe_end", 32'(eq_if.startEq1), 0);
    chk("g2r1_timer", 32'(eq_if.OngoingTimer), 3);

    // mid-round correct
    repeat (5) cyc();
    chk("g2r1_timer_mid", 32'(eq_if.OngoingTimer), 2);
    eq_if.correct = 1'b1;
    cyc();
    eq_if.correct = 1'b0;
    cyc();
    chk("g2r1_score", 32'(Score), 1);
    chk("g2r2_round", 32'(RoundNum), 2);
    chk("g2r2_strobe0", 32'(eq_if.startEq1), 1);
    cyc();
    chk("g2r2_strobe1", 32'(eq_if.startEq1), 1);
    chk("g2r2_timer_reload", 32'(eq_if.OngoingTimer), 3);
    cyc();
    chk("g2r2_strobe_end", 32'(eq_if.startEq1), 0);

    repeat (4) cyc();
    chk("g2r2_timer_two", 32'(eq_if.OngoingTimer), 2);
`ifdef MATHRIX_PAUSE_EN
    Pause = 1'b1;
    repeat (20) cyc();
    chk("g2r2_pause_hold", 32'(eq_if.OngoingTimer), 2);
    chk("g2r2_pause_no_timeout", 32'(Timeout), 0);
    Pause = 1'b0;
`endif

    // reset mid-round
    Reset = 1'b1;
    cyc();
    chk_all_zero("midreset");
    Reset = 1'b0;
    cyc();
    chk("post_reset_round", 32'(RoundNum), 0);
    chk("post_reset_strobe", 32'(eq_if.startEq1), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
